// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory responder: access size encodings,
// responder FSM states and the wait-state counter width.
package riscv_mem_pkg;

    // Access size encodings carried on req_size.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Width of the wait-state down-counter (WAIT_STATES is 0..15).
    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StExec,
        StResp
    } rsp_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic for 32-bit data memory accesses.
//   size_i      access size (SZ_B/SZ_H/SZ_W; 2'b11 illegal)
//   unsigned_i  zero-extend sub-word loads when 1, sign-extend when 0
//   addr_lo_i   byte offset within the word (addr[1:0])
//   wdata_i     right-aligned store data
//   rword_i     word read from storage
//   be_o        byte enables for a store
//   wword_o     store data replicated into all candidate lanes
//   rdata_o     extracted and extended load data
//   misalign_o  half on odd address or word not word-aligned
//   size_err_o  illegal size encoding
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        size_err_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o       = 4'b0000;
        wword_o    = 32'h0;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        size_err_o = 1'b0;
        // Bring the addressed lane down to bit 0.
        shifted    = rword_i >> {addr_lo_i, 3'b000};

        case (size_i)
            SZ_B: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{shifted[7] & ~unsigned_i}}, shifted[7:0]};
            end
            SZ_H: begin
                be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
                misalign_o = addr_lo_i[0];
                wword_o    = {2{wdata_i[15:0]}};
                rdata_o    = {{16{shifted[15] & ~unsigned_i}}, shifted[15:0]};
            end
            SZ_W: begin
                be_o       = 4'b1111;
                misalign_o = |addr_lo_i;
                wword_o    = wdata_i;
                rdata_o    = rword_i;
            end
            default: begin
                size_err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store at a time, accepted on a
// valid/ready request channel and completed on a valid/ready response channel
// after WAIT_STATES wait cycles plus one execute cycle.
//   clk, rst            clock; asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata  request fields
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata, rsp_err  load data (0 for stores/errors) and error flag
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // 33 bits so a full 4 GiB range still compares correctly.
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    rsp_state_e state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    // Request buffer.
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic buf_load;
    logic rsp_load;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic             in_range;
    logic [31:0]      rword;
    logic [3:0]       be;
    logic [31:0]      wword;
    logic [31:0]      lane_rdata;
    logic             misalign;
    logic             size_err;
    logic             err;
    logic             commit;

    assign word_idx = addr_q[IDX_W+1:2];
    assign in_range = {1'b0, addr_q} < BYTE_LIMIT;
    assign rword    = in_range ? mem[word_idx] : 32'h0;

    mem_lane_align u_lane (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .addr_lo_i  (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rword_i    (rword),
        .be_o       (be),
        .wword_o    (wword),
        .rdata_o    (lane_rdata),
        .misalign_o (misalign),
        .size_err_o (size_err)
    );

    assign err    = misalign | size_err | ~in_range;
    assign commit = (state_q == StExec) && we_q && !err;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buf_load = 1'b0;
        rsp_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    buf_load = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StExec;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StExec: begin
                rsp_load = 1'b1;
                state_d  = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (buf_load) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (rsp_load) begin
                rdata_q <= (err || we_q) ? 32'h0 : lane_rdata;
                err_q   <= err;
            end
        end
    end

    // Storage is not reset; a reset before the EXEC edge leaves state_q out of
    // StExec, so the store is dropped.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-array memory model with
// cycle-number timing, a per-cycle compare process, directed literal checks
// and randomized traffic.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mbytes [DEPTH*4];
    int          cyc = 0;
    int          acc = 0;
    bit          pending = 1'b0;
    bit          m_we;
    bit          m_uns;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] exp_rdata = 32'h0;
    bit          exp_err = 1'b0;
    bit          chk_en = 1'b0;

    // Executes the buffered access against the byte array (little endian).
    task automatic model_exec();
        int unsigned nb;
        logic [31:0] v;
        nb = (m_size == 2'b00) ? 1 : (m_size == 2'b01) ? 2 : 4;
        if (m_size == 2'b11 || (m_addr % nb) != 0 || m_addr >= DEPTH * 4) begin
            exp_err   = 1'b1;
            exp_rdata = 32'h0;
        end else if (m_we) begin
            exp_err   = 1'b0;
            exp_rdata = 32'h0;
            for (int i = 0; i < int'(nb); i++) mbytes[m_addr + i] = m_wdata[8*i +: 8];
        end else begin
            exp_err = 1'b0;
            v = 32'h0;
            for (int i = 0; i < int'(nb); i++) v[8*i +: 8] = mbytes[m_addr + i];
            if (!m_uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            exp_rdata = v;
        end
    endtask

    // Accept at edge acc, execute at edge acc+WS+1, response visible after it.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            pending = 1'b0;
        end else if (pending) begin
            if (cyc == acc + int'(WS) + 1) model_exec();
            else if (cyc > acc + int'(WS) + 1 && rsp_ready) pending = 1'b0;
        end else if (req_valid) begin
            pending = 1'b1;
            acc     = cyc;
            m_we    = req_we;
            m_uns   = req_unsigned;
            m_size  = req_size;
            m_addr  = req_addr;
            m_wdata = req_wdata;
        end
    end

    always @(negedge clk) begin
        logic ev;
        if (rst && chk_en) begin
            ev = pending && (cyc >= acc + int'(WS) + 1);
            check("req_ready", req_ready, !pending);
            check("rsp_valid", rsp_valid, ev);
            if (ev) begin
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", rsp_err, exp_err);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, input bit poke,
                          output logic [31:0] rd, output bit er, output int lat);
        int t;
        int w;
        rd  = 32'hx;
        er  = 1'b0;
        lat = -1;
        t   = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%0b, required 1", req_ready);
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        t = cyc;
        w = 0;
        while (!rsp_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!rsp_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%0b, required 1", rsp_valid);
            return;
        end
        lat = cyc - t;
        for (int i = 0; i < hold; i++) begin
            // Store request presented while busy; must be ignored.
            req_valid = poke && (i == 1);
            req_we    = 1'b1;
            req_size  = 2'b10;
            req_addr  = 32'h14;
            req_wdata = 32'h5555_5555;
            @(negedge clk);
        end
        req_valid = 1'b0;
        rd        = rsp_rdata;
        er        = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          er;
        int          lat;
        logic [31:0] addr;
        logic [1:0]  sz;
        int unsigned nb;
        int          r;

        // Reset values, in reset and after release.
        repeat (3) @(negedge clk);
        check("reset req_ready", req_ready, 1'b1);
        check("reset rsp_valid", rsp_valid, 1'b0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset rsp_err", rsp_err, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("post-reset req_ready", req_ready, 1'b1);
        check("post-reset rsp_valid", rsp_valid, 1'b0);
        chk_en = 1'b1;

        // Preload the exercised window.
        for (int a = 0; a < 256; a += 4) do_req(1'b1, 2'b10, 1'b0, a, $urandom, 0, 1'b0, rd, er, lat);

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, rd, er, lat);
        check("sw latency", lat, WS + 1);
        check("sw err", er, 1'b0);
        check("sw rdata", rd, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
        check("lw 0x10", rd, 32'hDEAD_BEEF);

        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 0, 1'b0, rd, er, lat);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, 1'b0, rd, er, lat);
        check("lb 0x13", rd, 32'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, 1'b0, rd, er, lat);
        check("lbu 0x13", rd, 32'h0000_0080);
        do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
        check("lhu 0x10", rd, 32'h0000_BEEF);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, 1'b0, rd, er, lat);
        check("lh 0x12", rd, 32'hFFFF_80AD);

        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 0, 1'b0, rd, er, lat);
        check("lw 0x12 err", er, 1'b1);
        check("lw 0x12 rdata", rd, 32'h0);
        do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h1234, 0, 1'b0, rd, er, lat);
        check("sh 0x11 err", er, 1'b1);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
        check("word after bad sh", rd, 32'h80AD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, DEPTH * 4, 32'h0, 0, 1'b0, rd, er, lat);
        check("out of range err", er, 1'b1);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er, lat);
        check("illegal size err", er, 1'b1);

        // Back-pressure with an ignored request pulse.
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h0BAD_CAFE, 0, 1'b0, rd, er, lat);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, 1'b1, rd, er, lat);
        check("backpressure rdata", rd, 32'h80AD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 0, 1'b0, rd, er, lat);
        check("ignored store", rd, 32'h0BAD_CAFE);

        // Reset during WAIT of a store.
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678, 0, 1'b0, rd, er, lat);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle after reset ready", req_ready, 1'b1);
        check("idle after reset valid", rsp_valid, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, 1'b0, rd, er, lat);
        check("dropped store", rd, 32'h1234_5678);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 15);
            if (r == 0) addr = DEPTH * 4 + $urandom_range(0, 7);
            else if (r == 1) addr = 32'hFFFF_FF00 | $urandom_range(0, 255);
            else addr = $urandom_range(0, 255);
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            if ($urandom_range(0, 1) == 1) addr = addr & ~(nb - 1);
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom,
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, er, lat);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
